motion_map_axis_tx: RTL and testbench

Output stage of the motion map generator. Takes the per-pixel grayscale value and motion decision produced each enabled cycle by the detection pipeline and buffers them in a small FIFO. It then transmits them as an AXI4-Stream video master carrying 32-bit {R,G,B,X} pixels, with an optional red motion overlay, frame/line markers and upstream flow control.

---
 rtl/motion_map_axis_tx_if.sv | 11 +
 rtl/motion_map_axis_tx.sv | 162 ++++++++++++++++
 tb/tb_motion_map_axis_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/motion_map_axis_tx_if.sv
// AXI4-Stream video beat bundle between the motion map output stage and its sink.
interface motion_map_axis_tx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/motion_map_axis_tx.sv
// Motion map output stage: pixel FIFO, one-deep output register and AXI4-Stream
// video framing (tuser on first pixel of a frame, tlast on last pixel of a line).
//
// state   | meaning
// S_EMPTY | output register holds no beat, tvalid low
// S_HOLD  | output register holds a beat, tvalid high until handshake
module motion_map_axis_tx #(
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 720,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_gray,
  input  logic                        in_motion,
  input  logic                        in_last_in_frame,
  input  logic                        overlay_en,
  output logic                        stall,
  motion_map_axis_tx_if.master        m_axis,
  output logic                        frame_done,
  output logic                        overflow,
  output logic                        sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   AFULL_LVL = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

  typedef enum logic {S_EMPTY, S_HOLD} ostate_t;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, fifo_rd, fifo_wr;
  logic [9:0]    head;

  ostate_t       state_q, state_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          eof_q, eof_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          sync_err_q, sync_err_d;
  logic          handshake, at_end;

  assign fifo_full  = (count_q == FULL_LVL);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign handshake  = (state_q == S_HOLD) && m_axis.tready;
  assign fifo_rd    = !fifo_empty && ((state_q == S_EMPTY) || handshake);
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_wr    = in_valid && (!fifo_full || fifo_rd);
  assign at_end     = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    count_d = count_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {in_gray, in_motion, in_last_in_frame};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    eof_d   = eof_q;
    case (state_q)
      S_EMPTY: if (fifo_rd) state_d = S_HOLD;
      S_HOLD:  if (handshake && !fifo_rd) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (fifo_rd) begin
      eof_d   = head[0];
      tdata_d = (head[1] && overlay_en) ? 32'hFF00_0001
                                        : {head[9:2], head[9:2], head[9:2], 7'b0, head[1]};
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
    overflow_d   = overflow_q | (in_valid && fifo_full && !fifo_rd);
    if (handshake) begin
      if (eof_q) begin
        col_d        = '0;
        row_d        = '0;
        frame_done_d = 1'b1;
        if (!at_end) sync_err_d = 1'b1;
      end else if (at_end) begin
        // Frame ran past WIDTH x HEIGHT without an eof marker: wrap and flag.
        col_d      = '0;
        row_d      = '0;
        sync_err_d = 1'b1;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      tdata_q      <= '0;
      eof_q        <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tdata_q      <= tdata_d;
      eof_q        <= eof_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign m_axis.tvalid = (state_q == S_HOLD);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = (col_q == COL_LAST);
  assign m_axis.tuser  = (col_q == '0) && (row_q == '0);
  assign stall         = (count_q >= AFULL_LVL);
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_motion_map_axis_tx.sv
// Directed bench for motion_map_axis_tx on a 4x2 frame with a 16-entry FIFO.
module tb_motion_map_axis_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_gray;
  logic       in_motion;
  logic       in_last_in_frame;
  logic       overlay_en;
  logic       stall;
  logic       frame_done;
  logic       overflow;
  logic       sync_err;

  motion_map_axis_tx_if m_axis ();

  motion_map_axis_tx #(
    .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(16), .AFULL_MARGIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_gray(in_gray),
    .in_motion(in_motion), .in_last_in_frame(in_last_in_frame),
    .overlay_en(overlay_en), .stall(stall), .m_axis(m_axis),
    .frame_done(frame_done), .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  q_gray [$];
  logic        q_mot  [$];
  logic        q_eof  [$];
  logic [31:0] b_data [$];
  logic        b_last [$];
  logic        b_user [$];
  int          b_cyc  [$];
  int          fd_cyc [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are already set for the coming rising edge; log what that edge will do.
  task automatic step();
    if (m_axis.tvalid && m_axis.tready) begin
      b_data.push_back(m_axis.tdata);
      b_last.push_back(m_axis.tlast);
      b_user.push_back(m_axis.tuser);
      b_cyc.push_back(cyc);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    b_data.delete(); b_last.delete(); b_user.delete(); b_cyc.delete(); fd_cyc.delete();
  endtask

  task automatic load_frame(input logic [7:0] base, input int n, input int eof_idx, input int mot_idx);
    for (int i = 0; i < n; i++) begin
      q_gray.push_back(8'(int'(base) + i));
      q_mot.push_back(i == mot_idx);
      q_eof.push_back(i == eof_idx);
    end
  endtask

  task automatic stream(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (q_gray.size() > 0) begin
        in_valid         = 1'b1;
        in_gray          = q_gray.pop_front();
        in_motion        = q_mot.pop_front();
        in_last_in_frame = q_eof.pop_front();
      end else begin
        in_valid = 1'b0; in_gray = 8'h00; in_motion = 1'b0; in_last_in_frame = 1'b0;
      end
      step();
    end
    in_valid = 1'b0; in_last_in_frame = 1'b0; in_motion = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] d,
                            input logic l, input logic u);
    if (i < b_data.size()) begin
      check({tag, " tdata"}, b_data[i], d);
      check({tag, " tlast"}, b_last[i], l);
      check({tag, " tuser"}, b_user[i], u);
    end else begin
      check({tag, " beat missing, count"}, b_data.size(), i + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_gray = 8'h00; in_motion = 1'b0;
    in_last_in_frame = 1'b0; overlay_en = 1'b0; m_axis.tready = 1'b1;
    @(negedge clk);
    #1;
    check("rst tvalid", m_axis.tvalid, 1'b0);
    check("rst tdata", m_axis.tdata, 32'h0);
    check("rst tlast", m_axis.tlast, 1'b0);
    check("rst tuser", m_axis.tuser, 1'b1);
    check("rst stall", stall, 1'b0);
    check("rst frame_done", frame_done, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst sync_err", sync_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Small frame, no motion, eof on pixel 7
    clear_log();
    load_frame(8'h10, 8, 7, -1);
    start = cyc;
    stream(16);
    check("t1 beat count", b_data.size(), 8);
    if (b_cyc.size() > 0) check("t1 latency", b_cyc[0] - start, 2);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] g;
      g = 8'(8'h10 + i);
      check_beat($sformatf("t1 beat%0d", i), i, {g, g, g, 8'h00}, (i == 3) || (i == 7), i == 0);
    end
    check("t1 fd pulses", fd_cyc.size(), 1);
    if (b_cyc.size() == 8 && fd_cyc.size() > 0) begin
      check("t1 back-to-back", b_cyc[7] - b_cyc[0], 7);
      check("t1 fd timing", fd_cyc[0], b_cyc[7] + 1);
    end
    check("t1 sync_err", sync_err, 1'b0);
    check("t1 overflow", overflow, 1'b0);

    // Motion overlay on pixel 2, with and without overlay_en
    overlay_en = 1'b1;
    clear_log();
    load_frame(8'h10, 8, 7, 2);
    stream(16);
    check_beat("t2 ovl beat2", 2, 32'hFF00_0001, 1'b0, 1'b0);
    check_beat("t2 ovl beat3", 3, 32'h1313_1300, 1'b1, 1'b0);
    overlay_en = 1'b0;
    clear_log();
    load_frame(8'h10, 8, 7, 2);
    stream(16);
    check_beat("t2 gray beat2", 2, 32'h1212_1201, 1'b0, 1'b0);
    check("t2 sync_err", sync_err, 1'b0);

    // Backpressure: sink stalled 20 cycles while upstream ignores stall
    clear_log();
    m_axis.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_gray = 8'(8'h40 + i); in_motion = 1'b0; in_last_in_frame = 1'b0;
      step();
      check($sformatf("t3 stall c%0d", i), stall, i >= 12);
      check($sformatf("t3 overflow c%0d", i), overflow, i >= 17);
      if (i >= 1) begin
        check($sformatf("t3 tvalid c%0d", i), m_axis.tvalid, 1'b1);
        check($sformatf("t3 tdata held c%0d", i), m_axis.tdata, 32'h4040_4000);
      end
    end
    in_valid = 1'b0;
    m_axis.tready = 1'b1;
    stream(30);
    check("t3 beat count", b_data.size(), 17);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] g;
      g = 8'(8'h40 + i);
      if (i < b_data.size()) check($sformatf("t3 beat%0d tdata", i), b_data[i], {g, g, g, 8'h00});
    end
    do_reset();
    check("t3 overflow after reset", overflow, 1'b0);
    check("t3 sync_err after reset", sync_err, 1'b0);

    // Early eof on pixel 5 of 8
    clear_log();
    load_frame(8'h60, 8, 5, -1);
    stream(16);
    check("t4 beat count", b_data.size(), 8);
    check_beat("t4 beat5", 5, 32'h6565_6500, 1'b0, 1'b0);
    check_beat("t4 beat6", 6, 32'h6666_6600, 1'b0, 1'b1);
    check_beat("t4 beat7", 7, 32'h6767_6700, 1'b0, 1'b0);
    check("t4 sync_err", sync_err, 1'b1);
    check("t4 fd pulses", fd_cyc.size(), 1);
    do_reset();

    // Missing eof: 9 pixels, none marked
    load_frame(8'h80, 9, -1, -1);
    stream(16);
    check("t5 beat count", b_data.size(), 9);
    check_beat("t5 beat7", 7, 32'h8787_8700, 1'b1, 1'b0);
    check_beat("t5 beat8", 8, 32'h8888_8800, 1'b0, 1'b1);
    check("t5 sync_err", sync_err, 1'b1);
    check("t5 fd pulses", fd_cyc.size(), 0);
    do_reset();

    // Reset mid-frame with tvalid high and overflow set
    m_axis.tready = 1'b0;
    load_frame(8'hA0, 20, -1, -1);
    stream(20);
    check("t6 pre tvalid", m_axis.tvalid, 1'b1);
    check("t6 pre overflow", overflow, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6 async tvalid", m_axis.tvalid, 1'b0);
    check("t6 async stall", stall, 1'b0);
    check("t6 async overflow", overflow, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    m_axis.tready = 1'b1;
    clear_log();
    load_frame(8'h77, 8, 7, -1);
    stream(16);
    check("t6 beat count", b_data.size(), 8);
    check_beat("t6 beat0", 0, 32'h7777_7700, 1'b0, 1'b1);
    check("t6 overflow", overflow, 1'b0);
    check("t6 sync_err", sync_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
